// File: rtl/router_pkg.sv
// Shared router constants and flit typedefs.
// The input buffer and its per-VC FIFOs size themselves from these defaults.
package router_pkg;

    localparam int DEF_FLITW    = 32;
    localparam int DEF_NUM_VC   = 4;
    localparam int DEF_VC_DEPTH = 4;
    localparam int DEF_VCW      = $clog2(DEF_NUM_VC);

    typedef logic [DEF_FLITW-1:0] flit_t;

    // The flit type occupies the two most significant bits of every flit.
    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    function automatic flit_type_e flit_type(input flit_t flit);
        return flit_type_e'(flit[DEF_FLITW-1 -: 2]);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO: storage, wrapping pointers, occupancy and a
// sticky overflow flag. The head flit is presented combinationally.
module vc_fifo #(
    parameter int FLITW = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [FLITW-1:0]           din,
    output logic [FLITW-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [FLITW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push_ok = push && (!full || pop_ok);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)
                count <= count + CW'(1);
            else if (pop_ok && !push_ok)
                count <= count - CW'(1);
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count, and
    // leaving it unreset lets it map onto plain flops or RAM without a clear tree.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign valid = !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/input_vc_buffer.sv
// Router input-port buffer: one FIFO per virtual channel, head flits exposed as
// a 2D array, and one registered credit pulse per dequeued flit.
module input_vc_buffer
    import router_pkg::*;
#(
    parameter int FLITW    = DEF_FLITW,
    parameter int NUM_VC   = DEF_NUM_VC,
    parameter int VC_DEPTH = DEF_VC_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [$clog2(NUM_VC)-1:0]     in_vc,
    input  logic [FLITW-1:0]              in_flit,
    input  logic [NUM_VC-1:0]             pop,
    output logic [FLITW-1:0]              out_data [NUM_VC],
    output logic [NUM_VC-1:0]             out_valid,
    output logic [NUM_VC-1:0]             credit_out,
    output logic [$clog2(VC_DEPTH+1)-1:0] vc_count [NUM_VC],
    output logic [NUM_VC-1:0]             overflow
);

    logic [NUM_VC-1:0] push_vc;
    logic [NUM_VC-1:0] pop_ok;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_vc = '0;
        if (in_valid) push_vc[in_vc] = 1'b1;
    end

    // Pops on empty VCs are neither dequeued nor credited.
    assign pop_ok = pop & out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) credit_out <= '0;
        else       credit_out <= pop_ok;
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        vc_fifo #(
            .FLITW (FLITW),
            .DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push_vc[i]),
            .pop      (pop_ok[i]),
            .din      (in_flit),
            .dout     (out_data[i]),
            .valid    (out_valid[i]),
            .count    (vc_count[i]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench for input_vc_buffer: expected flits queue per VC on push and
// are compared against the head flit when a pop is accepted.
module tb_input_vc_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_vc;
    logic [31:0] in_flit;
    logic [3:0]  pop;
    logic [31:0] out_data [4];
    logic [3:0]  out_valid;
    logic [3:0]  credit_out;
    logic [2:0]  vc_count [4];
    logic [3:0]  overflow;

    logic [31:0] exp_q [4][$];
    logic [3:0]  exp_ovf;
    int          n_checks;
    int          n_fail;

    input_vc_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_vc      (in_vc),
        .in_flit    (in_flit),
        .pop        (pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .credit_out (credit_out),
        .vc_count   (vc_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle from a negedge, updates the scoreboard, and checks the
    // registered outputs on the following negedge.
    task automatic drive(input logic pv, input logic [1:0] vc, input logic [31:0] f,
                         input logic [3:0] pm);
        logic [3:0]  exp_credit;
        logic [31:0] exp_head;
        exp_credit = '0;
        in_valid = pv;
        in_vc    = vc;
        in_flit  = f;
        pop      = pm;
        for (int i = 0; i < 4; i++) begin
            if (pm[i] && exp_q[i].size() > 0) begin
                exp_head = exp_q[i].pop_front();
                exp_credit[i] = 1'b1;
                n_checks++;
                if (out_data[i] !== exp_head) begin
                    n_fail++;
                    $display("FAIL pop_head vc%0d: got %h expected %h", i, out_data[i], exp_head);
                end
            end
        end
        if (pv) begin
            if (exp_q[vc].size() < 4) exp_q[vc].push_back(f);
            else                      exp_ovf[vc] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        pop      = '0;
        n_checks++;
        if (credit_out !== exp_credit) begin
            n_fail++;
            $display("FAIL credit: got %b expected %b", credit_out, exp_credit);
        end
        n_checks++;
        if (overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL overflow: got %b expected %b", overflow, exp_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid[i] !== (exp_q[i].size() != 0) || vc_count[i] !== 3'(exp_q[i].size())) begin
                n_fail++;
                $display("FAIL occupancy vc%0d: got valid=%b count=%0d expected count=%0d",
                         i, out_valid[i], vc_count[i], exp_q[i].size());
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (vc_count[i] !== 3'd0 || out_data[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_state vc%0d: got count=%0d data=%h expected 0/0", i, vc_count[i], out_data[i]);
            end
        end
        n_checks++;
        if (out_valid !== 4'b0 || credit_out !== 4'b0 || overflow !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b credit=%b ovf=%b expected 0", out_valid, credit_out, overflow);
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 2'd1, 32'h0000_0100 + 32'(k), 4'b0000);
        drive(1'b0, 2'd0, 32'd0, 4'b0010);
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 4'b0 || vc_count[1] !== 3'd0 || credit_out !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b count1=%0d credit=%b expected 0", out_valid, vc_count[1], credit_out);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q[1].delete();
        exp_ovf = '0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (credit_out !== 4'b0 || out_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset: got credit=%b valid=%b expected 0", credit_out, out_valid);
        end
    endtask

    task automatic test_single_flit();
        drive(1'b1, 2'd2, 32'hA5A5_0001, 4'b0000);
        n_checks++;
        if (out_valid !== 4'b0100 || out_data[2] !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL single_push: got valid=%b data=%h expected 0100/a5a50001", out_valid, out_data[2]);
        end
        drive(1'b0, 2'd0, 32'd0, 4'b0100);
        n_checks++;
        if (out_valid !== 4'b0000 || credit_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_pop: got valid=%b credit=%b expected 0000/0100", out_valid, credit_out);
        end
        drive(1'b0, 2'd0, 32'd0, 4'b0000);
    endtask

    task automatic test_fill_wrap();
        for (int k = 1; k <= 4; k++) drive(1'b1, 2'd0, 32'(k), 4'b0000);
        n_checks++;
        if (vc_count[0] !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_peak: got %0d expected 4", vc_count[0]);
        end
        drive(1'b0, 2'd0, 32'd0, 4'b0001);
        drive(1'b0, 2'd0, 32'd0, 4'b0001);
        drive(1'b1, 2'd0, 32'd5, 4'b0000);
        drive(1'b1, 2'd0, 32'd6, 4'b0000);
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 32'd0, 4'b0001);
        n_checks++;
        if (overflow !== 4'b0 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_end: got ovf=%b valid0=%b expected 0/0", overflow, out_valid[0]);
        end
    endtask

    task automatic test_empty_boundary();
        drive(1'b0, 2'd0, 32'd0, 4'b0010);
        drive(1'b1, 2'd1, 32'h0000_00E1, 4'b0010);
        n_checks++;
        if (vc_count[1] !== 3'd1 || out_data[1] !== 32'h0000_00E1) begin
            n_fail++;
            $display("FAIL empty_pushpop: got count=%0d head=%h expected 1/000000e1", vc_count[1], out_data[1]);
        end
        drive(1'b0, 2'd0, 32'd0, 4'b0010);
    endtask

    task automatic test_full_boundary();
        for (int k = 0; k < 4; k++) drive(1'b1, 2'd3, 32'h0000_0030 + 32'(k), 4'b0000);
        drive(1'b1, 2'd3, 32'h0000_0034, 4'b1000);
        n_checks++;
        if (vc_count[3] !== 3'd4 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL full_pushpop: got count=%0d ovf=%b expected 4/0000", vc_count[3], overflow);
        end
        drive(1'b1, 2'd3, 32'h0000_0035, 4'b0000);
        n_checks++;
        if (overflow !== 4'b1000 || out_data[3] !== 32'h0000_0031 || vc_count[3] !== 3'd4) begin
            n_fail++;
            $display("FAIL full_drop: got ovf=%b head=%h count=%0d expected 1000/00000031/4",
                     overflow, out_data[3], vc_count[3]);
        end
    endtask

    task automatic test_parallel();
        drive(1'b1, 2'd0, 32'h0000_00C0, 4'b0000);
        drive(1'b1, 2'd1, 32'h0000_00C1, 4'b0000);
        drive(1'b1, 2'd2, 32'h0000_00C2, 4'b0000);
        drive(1'b1, 2'd0, 32'h0000_00C3, 4'b1111);
        n_checks++;
        if (credit_out !== 4'b1111 || vc_count[0] !== 3'd1 || vc_count[1] !== 3'd0 ||
            vc_count[2] !== 3'd0 || vc_count[3] !== 3'd3) begin
            n_fail++;
            $display("FAIL parallel: got credit=%b counts=%0d/%0d/%0d/%0d expected 1111/1/0/0/3",
                     credit_out, vc_count[0], vc_count[1], vc_count[2], vc_count[3]);
        end
        for (int k = 0; k < 3; k++) drive(1'b0, 2'd0, 32'd0, 4'b1001);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ovf  = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_vc    = '0;
        in_flit  = '0;
        pop      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_flit();
        test_fill_wrap();
        test_empty_boundary();
        test_full_boundary();
        test_parallel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
